// File: rtl/rf_defs_pkg.sv
// Shared definitions for the register-bank write path.
//
// Purpose: default geometry of the 8-bit register bank (RF_NREQ, RF_DW, RF_AW)
// and the fixed requester slot assignment used by the write arbiter.
//
// Contents:
//   RF_NREQ    default number of write requesters
//   RF_DW      default register data width
//   RF_AW      default register address width
//   req_idx_e  requester slot numbers (writeback, load return, debug, spare)
package rf_defs_pkg;

    localparam int RF_NREQ = 4;
    localparam int RF_DW   = 8;
    localparam int RF_AW   = 3;

    // Slot 0 is the pipeline writeback. It is the one that can be given
    // fixed priority.
    typedef enum logic [2:0] {
        REQ_WB    = 3'd0,
        REQ_LD    = 3'd1,
        REQ_DBG   = 3'd2,
        REQ_SPARE = 3'd3
    } req_idx_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder.
//
// Purpose: returns the first set bit of elig at or after index ptr.
// The scan runs upward and wraps from NREQ-1 to 0.
//
// Ports:
//   elig    in   NREQ  candidate vector
//   ptr     in   PW    index where the scan starts
//   winner  out  PW    selected index (0 when valid=0)
//   valid   out  1     1 when any elig bit is set
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            valid
);

    // The sum needs one extra bit: ptr+off can reach 2*NREQ-2 before the wrap.
    logic [PW:0] sum;
    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum = {1'b0, ptr} + (PW+1)'(off);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!valid && elig[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Write-port arbiter for the 8-bit register bank.
//
// Purpose: shares the single bank write port between NREQ requesters.
// At most one write is granted per cycle, chosen round-robin.
// The winner's address and data are registered onto the bank.
// A requester whose grant is currently visible is not eligible that cycle.
//
// Optional feature: define RF_WR_ARB_FIXED_PRIO0_EN to give requester 0
// (pipeline writeback) absolute priority whenever it is eligible.
// Requesters 1..NREQ-1 then rotate among themselves.
//
// Ports:
//   CLK       in   1        clock
//   RST_N     in   1        asynchronous active-low reset
//   req       in   NREQ     per-requester write pending
//   req_addr  in   NREQ*AW  requester i address at [i*AW +: AW]
//   req_data  in   NREQ*DW  requester i data at [i*DW +: DW]
//   hold      in   1        bank unavailable, no grant this cycle
//   gnt       out  NREQ     registered one-hot grant
//   rf_we     out  1        registered bank write enable
//   rf_waddr  out  AW       registered bank write address
//   rf_wdata  out  DW       registered bank write data
//   busy      out  1        some request is unserved this cycle
module rf_wr_arbiter
    import rf_defs_pkg::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int DW   = RF_DW,
    parameter int AW   = RF_AW
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic              hold,
    output logic [NREQ-1:0]   gnt,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] rrElig;
    logic [PW-1:0]   rrPtr;
    logic [PW-1:0]   rrWinner;
    logic            rrValid;
    logic [PW-1:0]   winner;
    logic            valid;
    logic            movePtr;
    logic [PW-1:0]   nextPtr;
    logic [NREQ-1:0] winOneHot;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selData;

    // A requester is masked while its grant is visible.
    // This gives it time to retire the old data before it asks again.
    assign elig = req & ~gnt;
    assign busy = |elig;

`ifdef RF_WR_ARB_FIXED_PRIO0_EN
    // Slot 0 is handled by the override below.
    // The rotation therefore only sees slots 1..NREQ-1.
    assign rrElig = {elig[NREQ-1:1], 1'b0};
`else
    assign rrElig = elig;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .elig   (rrElig),
        .ptr    (rrPtr),
        .winner (rrWinner),
        .valid  (rrValid)
    );

    // Final winner selection and the mux of its address/data.
    // Writeback priority does not advance the rotation pointer.
    always_comb begin
        winner  = rrWinner;
        valid   = rrValid;
        movePtr = rrValid;
`ifdef RF_WR_ARB_FIXED_PRIO0_EN
        if (elig[REQ_WB]) begin
            winner  = PW'(REQ_WB);
            valid   = 1'b1;
            movePtr = 1'b0;
        end
`endif
        nextPtr   = (winner == LAST) ? '0 : winner + 1'b1;
        winOneHot = '0;
        selAddr   = '0;
        selData   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == PW'(i)) begin
                winOneHot[i] = 1'b1;
                selAddr      = req_addr[i*AW +: AW];
                selData      = req_data[i*DW +: DW];
            end
        end
    end

    // Output and pointer registers.
    // Address and data keep their last value when nothing is granted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gnt      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rrPtr    <= '0;
        end else if (!hold && valid) begin
            gnt      <= winOneHot;
            rf_we    <= 1'b1;
            rf_waddr <= selAddr;
            rf_wdata <= selData;
            if (movePtr) begin
                rrPtr <= nextPtr;
            end
        end else begin
            gnt   <= '0;
            rf_we <= 1'b0;
        end
    end

endmodule
